cache_fill_ctrl: RTL and testbench

Miss handler and line writer for the 4-way set-associative cache. It accepts a miss (tag, index) from the lookup path and picks a victim way. If the victim is dirty, it writes the victim line back to memory word by word. It then fetches the new line word by word, writes it into the data array, and commits the tag/valid/dirty metadata. It is the write-side counterpart of the lookup array: the only agent that fills or evicts lines.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_victim_select.sv | 29 ++
 rtl/cache_fill_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache configuration, derived constants and fill-controller state encoding.
// Imported by the fill controller, the victim selector and the lookup path.
package cache_pkg;

    localparam int unsigned CACHE_LINES     = 256;
    localparam int unsigned LINE_SIZE_BYTES = 64;
    localparam int unsigned TAG_BITS        = 18;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned WAYS            = 4;

    localparam int unsigned WORDS       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
    localparam int unsigned IDX_W       = $clog2(CACHE_LINES);
    localparam int unsigned WAY_W       = $clog2(WAYS);
    localparam int unsigned WORD_W      = $clog2(WORDS);
    localparam int unsigned ADDR_W      = TAG_BITS + IDX_W + OFFSET_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWbRd,
        StWbReq,
        StFill,
        StCommit
    } fill_state_t;

    // Word-aligned byte address of one word of a line in the default configuration.
    function automatic logic [ADDR_W-1:0] build_addr(
        input logic [TAG_BITS-1:0] tag,
        input logic [IDX_W-1:0]    index,
        input logic [WORD_W-1:0]   word
    );
        return {tag, index, word, {(OFFSET_BITS - WORD_W){1'b0}}};
    endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Combinational victim choice for one set: lowest invalid way, else lowest LRU-marked
// way, else way 0. Shared between the fill controller and the lookup path.
module cache_victim_select #(
    parameter int unsigned WAYS = cache_pkg::WAYS,
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  lru,
    output logic [WAY_W-1:0] victim
);
    import cache_pkg::*;

    // Scan high to low so the lowest matching index wins; the invalid scan runs last
    // so it overrides any LRU choice.
    always_comb begin
        victim = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (lru[i]) begin
                victim = WAY_W'(i);
            end
        end
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler: picks a victim, writes a dirty victim back word by word, refills the
// line from memory into the data array and commits the new tag.
module cache_fill_ctrl #(
    parameter int unsigned CACHE_LINES     = cache_pkg::CACHE_LINES,
    parameter int unsigned LINE_SIZE_BYTES = cache_pkg::LINE_SIZE_BYTES,
    parameter int unsigned TAG_BITS        = cache_pkg::TAG_BITS,
    parameter int unsigned DATA_WIDTH      = cache_pkg::DATA_WIDTH,
    parameter int unsigned WAYS            = cache_pkg::WAYS,
    localparam int unsigned WORDS  = LINE_SIZE_BYTES * 8 / DATA_WIDTH,
    localparam int unsigned IDX_W  = $clog2(CACHE_LINES),
    localparam int unsigned WAY_W  = $clog2(WAYS),
    localparam int unsigned WORD_W = $clog2(WORDS),
    localparam int unsigned ADDR_W = TAG_BITS + IDX_W + $clog2(LINE_SIZE_BYTES)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [TAG_BITS-1:0]      miss_tag,
    input  logic [IDX_W-1:0]         miss_index,

    input  logic [WAYS-1:0]          set_valid,
    input  logic [WAYS-1:0]          set_dirty,
    input  logic [WAYS-1:0]          set_lru,
    input  logic [WAYS*TAG_BITS-1:0] set_tags,

    output logic                     rd_en,
    output logic [IDX_W-1:0]         rd_index,
    output logic [WAY_W-1:0]         rd_way,
    output logic [WORD_W-1:0]        rd_word,
    input  logic [DATA_WIDTH-1:0]    rd_data,

    output logic                     wr_en,
    output logic [IDX_W-1:0]         wr_index,
    output logic [WAY_W-1:0]         wr_way,
    output logic [WORD_W-1:0]        wr_word,
    output logic [DATA_WIDTH-1:0]    wr_data,

    output logic                     meta_we,
    output logic [IDX_W-1:0]         meta_index,
    output logic [WAY_W-1:0]         meta_way,
    output logic [TAG_BITS-1:0]      meta_tag,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rsp_data,

    output logic                     fill_done,
    output logic [WAY_W-1:0]         fill_way
);
    import cache_pkg::*;

    localparam int unsigned BYTE_W = $clog2(LINE_SIZE_BYTES) - WORD_W;
    localparam int unsigned CNT_W  = WORD_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

    fill_state_t             state_q;
    logic                    miss_ready_q;
    logic [TAG_BITS-1:0]     tag_q;
    logic [IDX_W-1:0]        index_q;
    logic [WAY_W-1:0]        victim_q;
    logic [TAG_BITS-1:0]     vtag_q;
    logic [WORD_W-1:0]       word_q;
    logic                    wb_first_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]        req_cnt_q;
    logic [CNT_W-1:0]        rsp_cnt_q;

    logic [WAY_W-1:0]        victim_sel;
    logic [TAG_BITS-1:0]     victim_tag;
    logic                    req_fire;

    cache_victim_select #(
        .WAYS (WAYS)
    ) u_victim_select (
        .valid  (set_valid),
        .lru    (set_lru),
        .victim (victim_sel)
    );

    assign victim_tag = set_tags[int'(victim_sel) * TAG_BITS +: TAG_BITS];
    assign req_fire   = mem_req_valid && mem_req_ready;
    assign miss_ready = miss_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            miss_ready_q <= 1'b0;
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= '0;
            vtag_q       <= '0;
            word_q       <= '0;
            wb_first_q   <= 1'b0;
            wdata_q      <= '0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_valid && miss_ready_q) begin
                        tag_q        <= miss_tag;
                        index_q      <= miss_index;
                        miss_ready_q <= 1'b0;
                        state_q      <= StSelect;
                    end else begin
                        miss_ready_q <= 1'b1;
                    end
                end
                StSelect: begin
                    victim_q  <= victim_sel;
                    vtag_q    <= victim_tag;
                    word_q    <= '0;
                    req_cnt_q <= '0;
                    rsp_cnt_q <= '0;
                    if (set_valid[victim_sel] && set_dirty[victim_sel]) begin
                        state_q <= StWbRd;
                    end else begin
                        state_q <= StFill;
                    end
                end
                StWbRd: begin
                    wb_first_q <= 1'b1;
                    state_q    <= StWbReq;
                end
                StWbReq: begin
                    // rd_data is only valid in the first cycle after the read; hold it.
                    if (wb_first_q) begin
                        wdata_q    <= rd_data;
                        wb_first_q <= 1'b0;
                    end
                    if (req_fire) begin
                        if (word_q == WORD_LAST) begin
                            state_q <= StFill;
                        end else begin
                            word_q  <= word_q + 1'b1;
                            state_q <= StWbRd;
                        end
                    end
                end
                StFill: begin
                    if (req_fire) begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                    end
                    if (wr_en) begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        if (rsp_cnt_q == CNT_LAST) begin
                            state_q <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    miss_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // All outputs decode from registered state; only the fill write path and the
    // first writeback word pass an input straight through.
    always_comb begin
        rd_en         = 1'b0;
        rd_index      = '0;
        rd_way        = '0;
        rd_word       = '0;
        wr_en         = 1'b0;
        wr_index      = '0;
        wr_way        = '0;
        wr_word       = '0;
        wr_data       = '0;
        meta_we       = 1'b0;
        meta_index    = '0;
        meta_way      = '0;
        meta_tag      = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        fill_done     = 1'b0;
        fill_way      = '0;
        unique case (state_q)
            StWbRd: begin
                rd_en    = 1'b1;
                rd_index = index_q;
                rd_way   = victim_q;
                rd_word  = word_q;
            end
            StWbReq: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vtag_q, index_q, word_q, {BYTE_W{1'b0}}};
                mem_req_wdata = wb_first_q ? rd_data : wdata_q;
            end
            StFill: begin
                if (req_cnt_q < CNT_FULL) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {tag_q, index_q, req_cnt_q[WORD_W-1:0], {BYTE_W{1'b0}}};
                end
                if (mem_rsp_valid && (rsp_cnt_q < CNT_FULL)) begin
                    wr_en    = 1'b1;
                    wr_index = index_q;
                    wr_way   = victim_q;
                    wr_word  = rsp_cnt_q[WORD_W-1:0];
                    wr_data  = mem_rsp_data;
                end
            end
            StCommit: begin
                meta_we    = 1'b1;
                meta_index = index_q;
                meta_way   = victim_q;
                meta_tag   = tag_q;
                fill_done  = 1'b1;
                fill_way   = victim_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: clean/dirty fills, victim choice, backpressure,
// overlapping responses and mid-fill reset, against a small memory/data-array model.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [17:0] miss_tag;
    logic [7:0]  miss_index;
    logic [3:0]  set_valid;
    logic [3:0]  set_dirty;
    logic [3:0]  set_lru;
    logic [71:0] set_tags;
    logic        rd_en;
    logic [7:0]  rd_index;
    logic [1:0]  rd_way;
    logic [3:0]  rd_word;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_index;
    logic [1:0]  wr_way;
    logic [3:0]  wr_word;
    logic [31:0] wr_data;
    logic        meta_we;
    logic [7:0]  meta_index;
    logic [1:0]  meta_way;
    logic [17:0] meta_tag;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_done;
    logic [1:0]  fill_way;

    int n_checks = 0;
    int n_fail   = 0;

    cache_fill_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_tag      (miss_tag),
        .miss_index    (miss_index),
        .set_valid     (set_valid),
        .set_dirty     (set_dirty),
        .set_lru       (set_lru),
        .set_tags      (set_tags),
        .rd_en         (rd_en),
        .rd_index      (rd_index),
        .rd_way        (rd_way),
        .rd_word       (rd_word),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_index      (wr_index),
        .wr_way        (wr_way),
        .wr_word       (wr_word),
        .wr_data       (wr_data),
        .meta_we       (meta_we),
        .meta_index    (meta_index),
        .meta_way      (meta_way),
        .meta_tag      (meta_tag),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_done     (fill_done),
        .fill_way      (fill_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ":ctrl"}, {rd_en, wr_en, meta_we, mem_req_valid, mem_req_we, fill_done,
                                  miss_ready}, 64'h0);
        check_eq({tag, ":addr"}, mem_req_addr, 64'h0);
        check_eq({tag, ":wdata"}, {mem_req_wdata, wr_data}, 64'h0);
        check_eq({tag, ":sel"}, {rd_index, rd_way, rd_word, wr_index, wr_way, wr_word,
                                 meta_index, meta_way, meta_tag, fill_way}, 64'h0);
    endtask

    // Issue one miss and follow it cycle by cycle; called and returns just after a negedge.
    task automatic run_miss(
        input string       name,
        input logic [17:0] tag,
        input logic [7:0]  idx,
        input logic [3:0]  v,
        input logic [3:0]  d,
        input logic [3:0]  l,
        input logic [71:0] tags,
        input int          lat,
        input bit          bp,
        input logic [1:0]  exp_way,
        input bit          exp_wb,
        input logic [31:0] wb_base,
        input logic [31:0] rd_base,
        input int          exp_lat,
        input int          abort_at
    );
        int          t;
        int          waitc;
        int          nwb;
        int          nrd;
        int          nrq;
        int          nwr;
        int          nmeta;
        int          ndone;
        int          done_t;
        int          we_bad;
        int          rd_pw;
        bit          rd_pend;
        bit          prev_stall;
        bit          aborted;
        logic [63:0] prev_pay;
        int          due[$];
        logic [31:0] dat[$];

        nwb = 0; nrd = 0; nrq = 0; nwr = 0; nmeta = 0; ndone = 0; done_t = -10;
        we_bad = 0; rd_pw = 0; rd_pend = 1'b0; prev_stall = 1'b0; aborted = 1'b0;
        prev_pay = '0;

        waitc = 0;
        while (!miss_ready && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        check_eq({name, ":ready_before"}, miss_ready, 1);

        miss_valid    = 1'b1;
        miss_tag      = tag;
        miss_index    = idx;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        miss_valid = 1'b0;
        miss_tag   = 18'h3FFFF;
        miss_index = 8'hFF;
        set_valid  = v;
        set_dirty  = d;
        set_lru    = l;
        set_tags   = tags;
        t = 1;

        while (t < 400) begin
            mem_req_ready = bp ? ((t % 4) == 0 || (t % 4) == 3) : 1'b1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0BAD_0BAD;
            if (due.size() > 0 && due[0] == t) begin
                void'(due.pop_front());
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = dat.pop_front();
            end
            rd_data = rd_pend ? (32'hC0DE_0000 + 32'(rd_pw)) : 32'hDEAD_BEEF;
            rd_pend = 1'b0;
            #1;

            if (t == done_t + 1) begin
                check_eq({name, ":ready_after"}, {miss_ready, fill_done}, 2'b10);
                break;
            end

            if (mem_req_we && !mem_req_valid) we_bad++;
            if (mem_req_valid) begin
                if (prev_stall) begin
                    check_eq({name, ":hold"}, {mem_req_addr, mem_req_wdata}, prev_pay);
                end
                if (mem_req_ready) begin
                    prev_stall = 1'b0;
                    if (mem_req_we) begin
                        check_eq({name, ":wb_addr"}, mem_req_addr, wb_base + 32'(4 * nwb));
                        check_eq({name, ":wb_data"}, mem_req_wdata, 32'hC0DE_0000 + 32'(nwb));
                        nwb++;
                    end else begin
                        if (nrd == 0) check_eq({name, ":wb_before_rd"}, nwb, exp_wb ? 16 : 0);
                        check_eq({name, ":rd_addr"}, mem_req_addr, rd_base + 32'(4 * nrd));
                        due.push_back(t + lat);
                        dat.push_back((rd_base + 32'(4 * nrd)) ^ 32'h5A5A_5A5A);
                        nrd++;
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_pay   = {mem_req_addr, mem_req_wdata};
                end
            end else begin
                prev_stall = 1'b0;
            end

            if (rd_en) begin
                check_eq({name, ":rd_sel"}, {rd_index, rd_way, rd_word}, {idx, exp_way, 4'(nrq)});
                rd_pend = 1'b1;
                rd_pw   = nrq;
                nrq++;
            end
            if (wr_en) begin
                check_eq({name, ":wr_sel"}, {wr_index, wr_way, wr_word}, {idx, exp_way, 4'(nwr)});
                check_eq({name, ":wr_data"}, wr_data, (rd_base + 32'(4 * nwr)) ^ 32'h5A5A_5A5A);
                nwr++;
            end
            if (meta_we) begin
                check_eq({name, ":meta"}, {meta_index, meta_way, meta_tag}, {idx, exp_way, tag});
                nmeta++;
            end
            if (fill_done) begin
                check_eq({name, ":fill_way"}, {miss_ready, fill_way}, {1'b0, exp_way});
                ndone++;
                done_t = t;
            end

            if (abort_at >= 0 && nwr == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero({name, ":abort"});
                mem_rsp_valid = 1'b0;
                mem_req_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_eq({name, ":abort_meta"}, {meta_we, 32'(nmeta)}, 0);
                rst = 1'b0;
                #1;
                check_eq({name, ":ready_in_release"}, miss_ready, 0);
                @(posedge clk);
                #1;
                check_eq({name, ":ready_post_release"}, miss_ready, 1);
                @(negedge clk);
                aborted = 1'b1;
                break;
            end

            @(negedge clk);
            t++;
        end

        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (!aborted) begin
            check_eq({name, ":done_cnt"}, {32'(ndone), 32'(nmeta)}, {32'd1, 32'd1});
            check_eq({name, ":wb_cnt"}, nwb, exp_wb ? 16 : 0);
            check_eq({name, ":rd_cnt"}, {32'(nrd), 32'(nwr)}, {32'd16, 32'd16});
            check_eq({name, ":we_idle"}, we_bad, 0);
            if (exp_lat >= 0) check_eq({name, ":latency"}, done_t, exp_lat);
        end
    endtask

    initial begin
        rst           = 1'b1;
        miss_valid    = 1'b0;
        miss_tag      = '0;
        miss_index    = '0;
        set_valid     = '0;
        set_dirty     = '0;
        set_lru       = '0;
        set_tags      = '0;
        rd_data       = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check_eq("ready_at_release", miss_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_release", miss_ready, 1);

        // Stray response while idle must not write.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        #1;
        check_eq("stray_rsp", {wr_en, miss_ready}, 2'b01);
        @(negedge clk);
        mem_rsp_valid = 1'b0;

        run_miss("clean_inv", 18'h2ABCD, 8'h12, 4'b1011, 4'b0000, 4'b0000,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 2, 1'b0, 2'd2, 1'b0,
                 32'h0, 32'hAAF3_4480, 20, -1);
        run_miss("dirty_wb", 18'h00007, 8'h00, 4'b1111, 4'b0100, 4'b0100,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 2, 1'b0, 2'd2, 1'b1,
                 32'h0000_4000, 32'h0001_C000, 52, -1);
        run_miss("lru_none", 18'h12345, 8'hFF, 4'b1111, 4'b1110, 4'b0000,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 2, 1'b0, 2'd0, 1'b0,
                 32'h0, 32'h48D1_7FC0, 20, -1);
        run_miss("backpress", 18'h00100, 8'h80, 4'b1111, 4'b0010, 4'b1010,
                 {18'h00000, 18'h00000, 18'h3FFFF, 18'h00000}, 3, 1'b1, 2'd1, 1'b1,
                 32'hFFFF_E000, 32'h0040_2000, -1, -1);
        run_miss("overlap", 18'h00ABC, 8'h01, 4'b0111, 4'b0000, 4'b0000,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 1, 1'b0, 2'd3, 1'b0,
                 32'h0, 32'h02AF_0040, 19, -1);
        run_miss("abort", 18'h11111, 8'h22, 4'b1110, 4'b0000, 4'b0000,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 2, 1'b0, 2'd0, 1'b0,
                 32'h0, 32'h4444_4880, -1, 5);
        run_miss("after_abort", 18'h0F0F0, 8'h33, 4'b1111, 4'b0000, 4'b0001,
                 {18'h2AAAA, 18'h00001, 18'h15555, 18'h3C3C3}, 2, 1'b0, 2'd0, 1'b0,
                 32'h0, 32'h3C3C_0CC0, 20, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
